game_ctrl: RTL and testbench
============================

// Module: game_ctrl
// PURPOSE
//  Top-level game sequencer for the player sprite datapath. Runs the
//  IDLE/PLAY/SCROLL/OVER flow, holds the sprite in reset outside play, and
//  turns a climb above the scroll line into per-frame world-scroll pulses.
//  Accumulates score and best score. Sits beside the sprite motion block,
//  platform generator and renderer; its state byte drives their state inputs.
// PARAMETERS
//  H           480  screen height in pixels
//  SCROLL_LINE 160  sprite Y below which the world scrolls
//  DEATH_Y     446  sprite Y at or above which the game is lost
//  SCROLL_MAX  8    max scroll pixels per frame (1..15)
//  OVER_HOLD   120  frames OVER ignores input (1..255)
//  SCORE_W     16   score/best width
// PORTS
//  Clk            in   1        50 MHz system clock
//  Reset          in   1        async active-high reset
//  frame_clk_edge in   2        frame clock edge code; 2'b01 = frame tick
//  keycode        in   8        current keyboard scancode (0 = none)
//  doodle_y       in   10       sprite top-left Y, unsigned pixels
//  state          out  8        game state code (see BEHAVIOUR)
//  doodle_rst     out  1        holds sprite at spawn while high
//  scroll_px      out  4        scroll amount, valid with scroll_valid
//  scroll_valid   out  1        one-Clk pulse, world shifts down scroll_px
//  score          out  SCORE_W  current score (pixels climbed)
//  best           out  SCORE_W  best score since reset
// BEHAVIOUR
//  - Reset is asynchronous, active-high, and dominates all inputs. Reset
//    values: state=IDLE, doodle_rst=1, scroll_px=0, scroll_valid=0,
//    score=0, best=0, pending=0, hold counter=0.
//  - tick = (frame_clk_edge==2'b01). All decisions happen only on tick
//    cycles; all outputs are registered and update one Clk after the tick.
//  - Codes: IDLE 8'h00, PLAY 8'h01, SCROLL 8'h02, OVER 8'h03, PAUSE 8'h04.
//  - doodle_rst=1 in IDLE and OVER, else 0.
//  - IDLE: tick & keycode==8'h2C (space) -> PLAY; clear score and pending.
//  - PLAY on tick, first match wins: doodle_y>=DEATH_Y -> OVER;
//    doodle_y<SCROLL_LINE -> SCROLL with pending=SCROLL_LINE-doodle_y
//    (10-bit unsigned). Otherwise stay in PLAY.
//  - SCROLL on tick: if doodle_y>=DEATH_Y, go to OVER and emit no pulse.
//    Otherwise step=min(pending,SCROLL_MAX), scroll_valid=1 for one Clk,
//    scroll_px=step, pending-=step, score+=step. Score saturates at
//    2^SCORE_W-1. If the new pending==0, go to PLAY. A new
//    doodle_y<SCROLL_LINE seen while in SCROLL does not reload pending.
//  - scroll_valid is never high two Clk cycles in a row. scroll_px is
//    held at its last value when scroll_valid is low.
//  - OVER entry: hold counter=OVER_HOLD; best=score if score>best (same
//    cycle as the state change). Each tick decrements the counter
//    (stops at 0). When counter==0, tick & space -> IDLE. Score is
//    retained until the next IDLE->PLAY.
//  - Space held across OVER->IDLE: IDLE needs a fresh tick with space, so
//    IDLE->PLAY can happen on the next tick. This is accepted behaviour.
// CONFIGURATION
//  GAME_CTRL_PAUSE_EN defined: P-press = tick where keycode==8'h13 and the
//  keycode sampled on the previous tick !=8'h13. A P-press in PLAY or
//  SCROLL -> PAUSE, storing the return state. A P-press in PAUSE returns
//  to the stored state. PAUSE holds pending and score, emits no scroll,
//  keeps doodle_rst=0, and skips the death check.
//  Not defined: no PAUSE state, 8'h04 is never output, and 8'h13 is
//  ignored.
// TESTING
//  1 Reset mid-SCROLL (pending=20) -> next Clk state=00, doodle_rst=1,
//    scroll_valid=0, score=0, best=0.
//  2 IDLE, tick with keycode=2C -> state=01, doodle_rst=0;
//    tick with keycode=04 -> state stays 00.
//  3 PLAY, doodle_y=140, 4 ticks -> state=02; pulses 8,8,4 (one Clk
//    each); score=20; state=01 after the 3rd pulse.
//  4 SCROLL (pending=12), tick with doodle_y=450 -> state=03, no pulse;
//    score=30 vs best=25 -> best=30.
//  5 OVER, space on ticks 1..119 -> stays 03; space on tick 121 -> 00.
//  6 PAUSE_EN: PLAY, P held for 3 ticks -> 04 once; release, P again ->
//    01; doodle_y=460 while paused -> stays 04.

Source files
------------

// File: rtl/game_ctrl.sv
// game_ctrl: top-level game sequencer for the player sprite datapath.
//   Runs the IDLE/PLAY/SCROLL/OVER flow. Holds the sprite in reset outside
//   play. Turns a climb above the scroll line into per-frame world-scroll
//   pulses. Accumulates the current score and the best score.
//   Optional feature macro: GAME_CTRL_PAUSE_EN adds a PAUSE state that is
//   toggled by the P key.
// Ports:
//   Clk            system clock
//   Reset          async active-high reset
//   frame_clk_edge frame clock edge code, 2'b01 = frame tick
//   keycode        current keyboard scancode (0 = none)
//   doodle_y       sprite top-left Y, unsigned pixels
//   state          game state code (IDLE 00, PLAY 01, SCROLL 02, OVER 03, PAUSE 04)
//   doodle_rst     holds the sprite at spawn while high
//   scroll_px      scroll amount, valid with scroll_valid
//   scroll_valid   one-Clk pulse, world shifts down by scroll_px
//   score          current score (pixels climbed)
//   best           best score since reset
module game_ctrl #(
  parameter int H           = 480,
  parameter int SCROLL_LINE = 160,
  parameter int DEATH_Y     = 446,
  parameter int SCROLL_MAX  = 8,
  parameter int OVER_HOLD   = 120,
  parameter int SCORE_W     = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [1:0]         frame_clk_edge,
  input  logic [7:0]         keycode,
  input  logic [9:0]         doodle_y,
  output logic [7:0]         state,
  output logic               doodle_rst,
  output logic [3:0]         scroll_px,
  output logic               scroll_valid,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best
);

  // The death line is clamped to the last on-screen row.
  localparam logic [9:0] DEATH_V  = 10'((DEATH_Y < H) ? DEATH_Y : H - 1);
  localparam logic [9:0] LINE_V   = 10'(SCROLL_LINE);
  localparam logic [9:0] SMAX_V   = 10'(SCROLL_MAX);
  localparam logic [7:0] HOLD_V   = 8'(OVER_HOLD);
  localparam logic [7:0] KEY_SPC  = 8'h2C;
`ifdef GAME_CTRL_PAUSE_EN
  localparam logic [7:0] KEY_P    = 8'h13;
`endif

  typedef enum logic [7:0] {
    S_IDLE   = 8'h00,
    S_PLAY   = 8'h01,
    S_SCROLL = 8'h02,
`ifdef GAME_CTRL_PAUSE_EN
    S_PAUSE  = 8'h04,
`endif
    S_OVER   = 8'h03
  } state_t;

  state_t             state_q, state_n;
  logic [9:0]         pending_q, pending_n;
  logic [SCORE_W-1:0] score_q, score_n;
  logic [SCORE_W-1:0] best_q, best_n;
  logic [7:0]         hold_q, hold_n;
  logic [3:0]         px_q, px_n;
  logic               sv_q, sv_n;
  logic               rst_q, rst_n;

  logic               tick;
  logic               dead;
  logic               space;
  logic               enter_over;
  logic [9:0]         step;
  logic [SCORE_W:0]   sum;

`ifdef GAME_CTRL_PAUSE_EN
  state_t             ret_q, ret_n;
  logic [7:0]         prev_key_q, prev_key_n;
  logic               p_press;
`endif

  assign tick  = (frame_clk_edge == 2'b01);
  assign dead  = (doodle_y >= DEATH_V);
  assign space = (keycode == KEY_SPC);
  assign step  = (pending_q > SMAX_V) ? SMAX_V : pending_q;
  assign sum   = {1'b0, score_q} + {{(SCORE_W-9){1'b0}}, step};

`ifdef GAME_CTRL_PAUSE_EN
  assign p_press = tick && (keycode == KEY_P) && (prev_key_q != KEY_P);
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      score_q    <= '0;
      best_q     <= '0;
      hold_q     <= '0;
      px_q       <= '0;
      sv_q       <= 1'b0;
      rst_q      <= 1'b1;
`ifdef GAME_CTRL_PAUSE_EN
      ret_q      <= S_PLAY;
      prev_key_q <= '0;
`endif
    end else begin
      state_q    <= state_n;
      pending_q  <= pending_n;
      score_q    <= score_n;
      best_q     <= best_n;
      hold_q     <= hold_n;
      px_q       <= px_n;
      sv_q       <= sv_n;
      rst_q      <= rst_n;
`ifdef GAME_CTRL_PAUSE_EN
      ret_q      <= ret_n;
      prev_key_q <= prev_key_n;
`endif
    end
  end

  always_comb begin
    state_n    = state_q;
    pending_n  = pending_q;
    score_n    = score_q;
    best_n     = best_q;
    hold_n     = hold_q;
    px_n       = px_q;
    sv_n       = 1'b0;
    enter_over = 1'b0;
`ifdef GAME_CTRL_PAUSE_EN
    ret_n      = ret_q;
    prev_key_n = tick ? keycode : prev_key_q;
`endif

    if (tick) begin
`ifdef GAME_CTRL_PAUSE_EN
      if (p_press && (state_q == S_PLAY || state_q == S_SCROLL)) begin
        ret_n   = state_q;
        state_n = S_PAUSE;
      end else if (p_press && state_q == S_PAUSE) begin
        state_n = ret_q;
      end else
`endif
      begin
        case (state_q)
          S_IDLE: begin
            if (space) begin
              state_n   = S_PLAY;
              score_n   = '0;
              pending_n = '0;
            end
          end
          S_PLAY: begin
            if (dead) begin
              enter_over = 1'b1;
            end else if (doodle_y < LINE_V) begin
              state_n   = S_SCROLL;
              pending_n = LINE_V - doodle_y;
            end
          end
          S_SCROLL: begin
            if (dead) begin
              enter_over = 1'b1;
            // Back-to-back ticks must not produce back-to-back pulses.
            end else if (!sv_q) begin
              sv_n      = 1'b1;
              px_n      = step[3:0];
              pending_n = pending_q - step;
              score_n   = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
              if (pending_q == step)
                state_n = S_PLAY;
            end
          end
          S_OVER: begin
            if (hold_q != 8'd0)
              hold_n = hold_q - 8'd1;
            else if (space)
              state_n = S_IDLE;
          end
          default: ;
        endcase
      end
    end

    if (enter_over) begin
      state_n = S_OVER;
      hold_n  = HOLD_V;
      if (score_q > best_q)
        best_n = score_q;
    end

    rst_n = (state_n == S_IDLE) || (state_n == S_OVER);
  end

  assign state        = state_q;
  assign doodle_rst   = rst_q;
  assign scroll_px    = px_q;
  assign scroll_valid = sv_q;
  assign score        = score_q;
  assign best         = best_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed self-checking bench for game_ctrl.
module tb_game_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  frame_clk_edge = 2'b00;
  logic [7:0]  keycode = 8'h00;
  logic [9:0]  doodle_y = 10'd300;
  logic [7:0]  state;
  logic        doodle_rst;
  logic [3:0]  scroll_px;
  logic        scroll_valid;
  logic [15:0] score;
  logic [15:0] best;

  int unsigned tests = 0;
  int unsigned fails = 0;

  game_ctrl #(
    .H(480), .SCROLL_LINE(160), .DEATH_Y(446),
    .SCROLL_MAX(8), .OVER_HOLD(120), .SCORE_W(16)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk_edge(frame_clk_edge),
    .keycode(keycode), .doodle_y(doodle_y), .state(state),
    .doodle_rst(doodle_rst), .scroll_px(scroll_px),
    .scroll_valid(scroll_valid), .score(score), .best(best)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One tick: inputs presented for one Clk with the tick code, then
  // withdrawn; returns half a cycle after the sampling edge.
  task automatic tick(input logic [7:0] key, input logic [9:0] y);
    @(negedge Clk);
    keycode = key;
    doodle_y = y;
    frame_clk_edge = 2'b01;
    @(negedge Clk);
    frame_clk_edge = 2'b00;
    keycode = 8'h00;
  endtask

  // OVER ignores space for 120 ticks, then space on the next tick exits.
  task automatic over_release();
    for (int i = 1; i <= 120; i++) begin
      tick(8'h2C, 10'd300);
      chk($sformatf("over_hold_%0d", i), state, 8'h03);
    end
    tick(8'h2C, 10'd300);
    chk("over_exit", state, 8'h00);
    chk("over_exit_rst", doodle_rst, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_state", state, 8'h00);
    chk("rst_doodle_rst", doodle_rst, 1'b1);
    chk("rst_sv", scroll_valid, 1'b0);
    chk("rst_px", scroll_px, 4'd0);
    chk("rst_score", score, 16'd0);
    chk("rst_best", best, 16'd0);
    Reset = 1'b0;

    // Space without a tick code is ignored
    @(negedge Clk);
    keycode = 8'h2C;
    frame_clk_edge = 2'b10;
    @(negedge Clk);
    frame_clk_edge = 2'b00;
    keycode = 8'h00;
    chk("idle_no_tick", state, 8'h00);

    tick(8'h04, 10'd300);
    chk("idle_other_key", state, 8'h00);
    tick(8'h2C, 10'd300);
    chk("idle_to_play", state, 8'h01);
    chk("play_rst", doodle_rst, 1'b0);

    // Game 1: boundaries, then climb of 20
    tick(8'h00, 10'd160);
    chk("line_boundary", state, 8'h01);
    tick(8'h00, 10'd445);
    chk("death_boundary_minus1", state, 8'h01);
    tick(8'h00, 10'd140);
    chk("enter_scroll", state, 8'h02);
    chk("enter_scroll_sv", scroll_valid, 1'b0);
    tick(8'h00, 10'd140);
    chk("p1_sv", scroll_valid, 1'b1);
    chk("p1_px", scroll_px, 4'd8);
    chk("p1_score", score, 16'd8);
    chk("p1_state", state, 8'h02);
    @(negedge Clk);
    chk("p1_sv_drop", scroll_valid, 1'b0);
    chk("p1_px_hold", scroll_px, 4'd8);
    tick(8'h00, 10'd140);
    chk("p2_px", scroll_px, 4'd8);
    chk("p2_score", score, 16'd16);
    tick(8'h00, 10'd140);
    chk("p3_sv", scroll_valid, 1'b1);
    chk("p3_px", scroll_px, 4'd4);
    chk("p3_score", score, 16'd20);
    chk("p3_state", state, 8'h01);
    @(negedge Clk);
    chk("p3_sv_drop", scroll_valid, 1'b0);
    chk("p3_px_hold", scroll_px, 4'd4);
    tick(8'h00, 10'd446);
    chk("g1_over", state, 8'h03);
    chk("g1_over_rst", doodle_rst, 1'b1);
    chk("g1_best", best, 16'd20);
    over_release();
    chk("score_retained", score, 16'd20);

    // Game 2: reach score 30 with pending 12, then die in SCROLL
    tick(8'h2C, 10'd300);
    chk("g2_play", state, 8'h01);
    chk("g2_score_clr", score, 16'd0);
    tick(8'h00, 10'd138);
    chk("g2_scroll", state, 8'h02);
    tick(8'h00, 10'd300);
    chk("g2_a_px", scroll_px, 4'd8);
    tick(8'h00, 10'd300);
    chk("g2_b_px", scroll_px, 4'd8);
    tick(8'h00, 10'd300);
    chk("g2_c_px", scroll_px, 4'd6);
    chk("g2_c_score", score, 16'd22);
    chk("g2_c_state", state, 8'h01);
    tick(8'h00, 10'd140);
    chk("g2_scroll2", state, 8'h02);
    tick(8'h00, 10'd300);
    chk("g2_d_px", scroll_px, 4'd8);
    chk("g2_d_score", score, 16'd30);
    tick(8'h00, 10'd450);
    chk("g2_over", state, 8'h03);
    chk("g2_over_nopulse", scroll_valid, 1'b0);
    chk("g2_score", score, 16'd30);
    chk("g2_best", best, 16'd30);
    over_release();

    // Game 3: lower score leaves best alone
    tick(8'h2C, 10'd300);
    tick(8'h00, 10'd150);
    tick(8'h00, 10'd300);
    chk("g3_a_px", scroll_px, 4'd8);
    tick(8'h00, 10'd300);
    chk("g3_b_px", scroll_px, 4'd2);
    chk("g3_b_state", state, 8'h01);
    tick(8'h00, 10'd446);
    chk("g3_over", state, 8'h03);
    chk("g3_score", score, 16'd10);
    chk("g3_best_kept", best, 16'd30);
    over_release();

    // Asynchronous reset in the middle of a scroll
    tick(8'h2C, 10'd300);
    tick(8'h00, 10'd140);
    tick(8'h00, 10'd300);
    chk("g4_score", score, 16'd8);
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_state", state, 8'h00);
    chk("arst_rst", doodle_rst, 1'b1);
    chk("arst_sv", scroll_valid, 1'b0);
    chk("arst_score", score, 16'd0);
    chk("arst_best", best, 16'd0);
    @(negedge Clk);
    Reset = 1'b0;
    tick(8'h2C, 10'd300);
    chk("post_rst_play", state, 8'h01);

`ifdef GAME_CTRL_PAUSE_EN
    tick(8'h13, 10'd300);
    chk("pause_enter", state, 8'h04);
    chk("pause_rst", doodle_rst, 1'b0);
    tick(8'h13, 10'd300);
    chk("pause_held1", state, 8'h04);
    tick(8'h13, 10'd300);
    chk("pause_held2", state, 8'h04);
    tick(8'h00, 10'd460);
    chk("pause_no_death", state, 8'h04);
    tick(8'h13, 10'd300);
    chk("pause_exit", state, 8'h01);
`else
    tick(8'h13, 10'd300);
    chk("p_ignored", state, 8'h01);
    tick(8'h13, 10'd140);
    chk("p_ignored_scroll", state, 8'h02);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
